// File: rtl/add_bfm.sv
// Registered unsigned adder with a parameterisable pipeline latency and
// optional saturation on carry-out; res_o is the final pipeline stage.
module add_bfm #(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] stage0_d;
  logic [WIDTH-1:0] pipe [LATENCY];

  // Carry-out selects between clamping and plain modulo truncation.
  always_comb begin
    sum      = {1'b0, A_s} + {1'b0, B_s};
    stage0_d = sum[WIDTH-1:0];
    if ((SATURATE != 0) && sum[WIDTH]) begin
      stage0_d = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= stage0_d;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign res_o = pipe[LATENCY-1];

endmodule

// File: tb/tb_add_bfm.sv
// Bench for add_bfm: three configurations share one operand stream and are
// compared each cycle against queue-based delay models plus directed constants.
module tb_add_bfm;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] A_s;
  logic [7:0] B_s;
  logic [7:0] res_l1;
  logic [7:0] res_sat;
  logic [7:0] res_l3;

  int n_checks;
  int n_errors;

  // Expected-value queues: front entry is what res_o should show now.
  logic [7:0] q1[$];
  logic [7:0] qs[$];
  logic [7:0] q3[$];

  add_bfm #(.WIDTH(8), .LATENCY(1), .SATURATE(0)) u_l1 (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_l1));
  add_bfm #(.WIDTH(8), .LATENCY(1), .SATURATE(1)) u_sat (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_sat));
  add_bfm #(.WIDTH(8), .LATENCY(3), .SATURATE(0)) u_l3 (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res_l3));

  // Clock / reset block
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle with given operands and reset, then model update and check.
  task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic r);
    int s;
    @(negedge clk_i);
    A_s = a;
    B_s = b;
    reset_i = r;
    @(posedge clk_i);
    if (r) begin
      q1 = '{8'd0};
      qs = '{8'd0};
      q3 = '{8'd0, 8'd0, 8'd0};
    end else begin
      s = int'(a) + int'(b);
      q1.push_back(8'(s % 256));
      qs.push_back((s > 255) ? 8'd255 : 8'(s));
      q3.push_back(8'(s % 256));
      if (q1.size() > 1) void'(q1.pop_front());
      if (qs.size() > 1) void'(qs.pop_front());
      if (q3.size() > 3) void'(q3.pop_front());
    end
    #1;
    check("model_l1", res_l1, q1[0]);
    check("model_sat", res_sat, qs[0]);
    check("model_l3", res_l3, q3[0]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    A_s = 8'd0;
    B_s = 8'd0;
    reset_i = 1'b1;

    // Reset two cycles with operands already present
    cyc(8'd1, 8'd2, 1'b1);
    check("rst_l1", res_l1, 8'd0);
    check("rst_l3", res_l3, 8'd0);
    cyc(8'd1, 8'd2, 1'b1);
    check("rst2_l1", res_l1, 8'd0);

    // Constant operands held: res_o becomes 3 right after first non-reset edge
    cyc(8'd1, 8'd2, 1'b0);
    check("hold_first_l1", res_l1, 8'd3);
    check("hold_first_l3", res_l3, 8'd0);
    for (int i = 0; i < 1999; i++) begin
      cyc(8'd1, 8'd2, 1'b0);
    end
    check("hold_end_l1", res_l1, 8'd3);
    check("hold_end_l3", res_l3, 8'd3);

    // Wrap vs saturate
    cyc(8'd200, 8'd100, 1'b0);
    check("wrap_200_100", res_l1, 8'd44);
    check("sat_200_100", res_sat, 8'd255);
    cyc(8'd255, 8'd1, 1'b0);
    check("wrap_255_1", res_l1, 8'd0);
    check("sat_255_1", res_sat, 8'd255);
    cyc(8'd127, 8'd128, 1'b0);
    check("sat_127_128", res_sat, 8'd255);
    check("wrap_127_128", res_l1, 8'd255);
    cyc(8'd10, 8'd20, 1'b0);
    check("sat_10_20", res_sat, 8'd30);
    cyc(8'd0, 8'd0, 1'b0);
    check("wrap_0_0", res_l1, 8'd0);

    // Latency 3 back-to-back sequence
    cyc(8'd1, 8'd2, 1'b0);
    cyc(8'd3, 8'd4, 1'b0);
    cyc(8'd5, 8'd6, 1'b0);
    check("l3_seq0", res_l3, 8'd3);
    cyc(8'd0, 8'd0, 1'b0);
    check("l3_seq1", res_l3, 8'd7);
    cyc(8'd0, 8'd0, 1'b0);
    check("l3_seq2", res_l3, 8'd11);

    // Reset mid-stream discards in-flight sums
    cyc(8'd10, 8'd10, 1'b0);
    cyc(8'd20, 8'd20, 1'b0);
    cyc(8'd30, 8'd30, 1'b1);
    check("mid_rst_edge", res_l3, 8'd0);
    cyc(8'd1, 8'd1, 1'b0);
    check("mid_rst_p1", res_l3, 8'd0);
    cyc(8'd2, 8'd2, 1'b0);
    check("mid_rst_p2", res_l3, 8'd0);
    cyc(8'd3, 8'd3, 1'b0);
    check("mid_rst_p3", res_l3, 8'd2);

    // Random operands with rare reset pulses
    for (int i = 0; i < 10000; i++) begin
      cyc(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
